ram_sdp_init: RTL and testbench



---
 rtl/ram_sdp_init.sv | 159 +++++++++++++++
 tb/tb_ram_sdp_init.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_init.sv
// ram_sdp_init: parametrised simple-dual-port synchronous RAM.
// A self-clearing sequencer zeroes every word after each reset release.
// The read port is registered and has a one-cycle valid strobe.
// Optional build macro: RAM_OUT_REG_EN
//   When defined, an extra output register stage is added (read latency 2).
module ram_sdp_init #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned RDW_NEW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              init_busy,
    output logic              wr_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    // Muxed memory write port: the clear sequencer owns it during CLEAR
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Read request accepted this cycle and the word it returns
    logic              rd_en_c;
    logic              rdw_hit_c;
    logic [DATA_W-1:0] rd_data_c;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] dout_s1;
    logic              valid_s1;

    // State register and clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state logic; also selects who drives the memory write port
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        mem_we_c    = 1'b0;
        mem_waddr_c = waddr;
        mem_wdata_c = din;
        rd_en_c     = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt;
                mem_wdata_c = '0;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = ST_RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                mem_we_c = we;
                rd_en_c  = re;
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Storage array; contents are defined by the clear sequence, not by reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Same-address collision bypass selects write data when RDW_NEW is set
    always_comb begin
        rdw_hit_c = (RDW_NEW != 32'd0) && we && (waddr == raddr);
        rd_data_c = rdw_hit_c ? din : mem[raddr];
    end

    // First read stage: data holds when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_s1  <= '0;
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= rd_en_c;
            if (rd_en_c) begin
                dout_s1 <= rd_data_c;
            end
        end
    end

    // Busy flag tracks the state the FSM is entering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_busy <= 1'b1;
        end else begin
            init_busy <= (state_nxt == ST_CLEAR);
        end
    end

    // Sticky record of writes lost to the clear sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else if ((state == ST_CLEAR) && we) begin
            wr_drop <= 1'b1;
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] dout_s2;
    logic              valid_s2;

    // Second output stage delays data and strobe together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_s2  <= '0;
            valid_s2 <= 1'b0;
        end else begin
            dout_s2  <= dout_s1;
            valid_s2 <= valid_s1;
        end
    end

    assign dout       = dout_s2;
    assign dout_valid = valid_s2;
`else
    assign dout       = dout_s1;
    assign dout_valid = valid_s1;
`endif

endmodule

// File: tb/tb_ram_sdp_init.sv
// Testbench for ram_sdp_init: two instances (old-data and new-data collision
// policy) share one stimulus stream and are compared every cycle against a
// word-level reference model of the memory.
module tb_ram_sdp_init;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
`ifdef RAM_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] din;
    logic              re;
    logic [ADDR_W-1:0] raddr;

    logic [DATA_W-1:0] dout_old, dout_new;
    logic              dv_old, dv_new;
    logic              busy_old, busy_new;
    logic              drop_old, drop_new;

    int n_checks;
    int n_errors;

    // Reference model: memory image, pending clear cycles, read pipeline
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                clr_left;
    bit                m_drop;
    logic [DATA_W-1:0] m_s1 [2];
    logic [DATA_W-1:0] m_s2 [2];
    bit                m_v1;
    bit                m_v2;

    ram_sdp_init #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_NEW(0)) u_dut_old (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(dout_old), .dout_valid(dv_old),
        .init_busy(busy_old), .wr_drop(drop_old)
    );

    ram_sdp_init #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_NEW(1)) u_dut_new (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(dout_new), .dout_valid(dv_new),
        .init_busy(busy_new), .wr_drop(drop_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        clr_left = DEPTH;
        m_drop   = 1'b0;
        m_v1     = 1'b0;
        m_v2     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = '0;
            m_s2[k] = '0;
        end
        // Memory is all-zero once the clear completes; reads cannot see it earlier
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    endtask

    task automatic model_edge(input bit t_we, input int t_wa, input logic [DATA_W-1:0] t_d,
                              input bit t_re, input int t_ra);
        m_v2 = m_v1;
        for (int k = 0; k < 2; k++) m_s2[k] = m_s1[k];
        if (clr_left > 0) begin
            if (t_we) m_drop = 1'b1;
            m_v1 = 1'b0;
            clr_left--;
        end else begin
            m_v1 = t_re;
            if (t_re) begin
                m_s1[0] = m_mem[t_ra];
                m_s1[1] = (t_we && t_wa == t_ra) ? t_d : m_mem[t_ra];
            end
            if (t_we) m_mem[t_wa] = t_d;
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_dout(input int k);
        return (LAT == 2) ? m_s2[k] : m_s1[k];
    endfunction

    function automatic bit exp_valid();
        return (LAT == 2) ? m_v2 : m_v1;
    endfunction

    task automatic compare_all();
        check("dout_old",  32'(dout_old), 32'(exp_dout(0)));
        check("dout_new",  32'(dout_new), 32'(exp_dout(1)));
        check("valid_old", 32'(dv_old),   32'(exp_valid()));
        check("valid_new", 32'(dv_new),   32'(exp_valid()));
        check("busy_old",  32'(busy_old), 32'(clr_left > 0));
        check("busy_new",  32'(busy_new), 32'(clr_left > 0));
        check("drop_old",  32'(drop_old), 32'(m_drop));
        check("drop_new",  32'(drop_new), 32'(m_drop));
    endtask

    // One clock: drive at the falling edge, update model at the rising edge, compare next falling edge
    task automatic cyc(input bit t_we, input int t_wa, input logic [DATA_W-1:0] t_d,
                       input bit t_re, input int t_ra);
        we    = t_we;
        waddr = ADDR_W'(t_wa);
        din   = t_d;
        re    = t_re;
        raddr = ADDR_W'(t_ra);
        @(posedge clk);
        if (rst_n) model_edge(t_we, t_wa, t_d, t_re, t_ra);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, 1'b0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        we    = 1'b0;
        waddr = '0;
        din   = '0;
        re    = 1'b0;
        raddr = '0;
        model_reset();

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        compare_all();
        idle(2);

        // Release; a write and read during CLEAR must be dropped/ignored
        rst_n = 1'b1;
        cyc(1'b1, 1, 4'b1001, 1'b1, 1);
        idle(int'(DEPTH) - 1);

        // Freshly cleared memory reads back zero, including the dropped address
        for (int a = 0; a < int'(DEPTH); a++) cyc(1'b0, 0, '0, 1'b1, a);
        idle(2);

        // Directed pattern writes and read-back
        cyc(1'b1, 0, 4'b1010, 1'b0, 0);
        cyc(1'b1, 1, 4'b1100, 1'b0, 0);
        cyc(1'b1, 2, 4'b0101, 1'b0, 0);
        cyc(1'b1, 3, 4'b1111, 1'b0, 0);
        for (int a = 0; a < int'(DEPTH); a++) cyc(1'b0, 0, '0, 1'b1, a);
        idle(2);

        // Same-address collision, then a plain read of the same word
        cyc(1'b1, 2, 4'b0011, 1'b1, 2);
        cyc(1'b0, 0, '0, 1'b1, 2);
        idle(2);

        // Randomised traffic; small address space gives frequent collisions
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                DATA_W'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, DEPTH - 1)));
        end
        idle(2);

        // Reset in the middle of RUN after loading address 3
        cyc(1'b1, 3, 4'b1111, 1'b0, 0);
        cyc(1'b0, 0, '0, 1'b1, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                DATA_W'($urandom), 1'b1, int'($urandom_range(0, DEPTH - 1)));
        end
        cyc(1'b0, 0, '0, 1'b1, 3);
        idle(3);

        // Second randomised burst after the re-clear
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                DATA_W'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, DEPTH - 1)));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
